rgb_clamp_pack: RTL
===================

# rgb_clamp_pack

Downstream stage of the YUV-to-RGB converter. Takes the converter's per-pixel 13-bit signed fixed-point R/G/B (3 fractional bits) and its one-cycle valid strobe, rounds and saturates each channel to 8 bits, and buffers pixels in a small FIFO. Pixels leave as a serial R, G, B byte stream under a valid/ready handshake. The upstream converter has no backpressure, so overflow drops pixels and raises a sticky flag.

## Interface
- `IN_W`, default 13: input channel width; two's complement, 3 fractional bits.
- `FIFO_DEPTH`, default 8: pixel FIFO depth; must be a power of 2 and at least 2.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: reset, asynchronous, active-low; clears all state.
- `R`, `G`, `B` input `IN_W`: channel values from the converter.
- `sys_valid` input 1: one-cycle strobe; R/G/B are valid in this cycle.
- `clr_ovf` input 1: synchronous clear of `overflow`.
- `dout` output 8: current output byte.
- `dout_valid` output 1: `dout` holds a byte.
- `dout_ready` input 1: sink accepts the byte on an edge where both valid and ready are high.
- `dout_first` output 1: high while `dout` carries the R byte of a pixel.
- `fifo_level` output `$clog2(FIFO_DEPTH)+1`: number of pixels in the FIFO.
- `overflow` output 1: sticky; a pixel was dropped.

## Operation
- **Conversion, per channel:** `x` is sign-extended to `IN_W+1` bits, then `y = (x + 4) >>> 3` (arithmetic shift, round half up).
  - If `y < 0`, the output is 0.
  - If `y > 255`, the output is 255.
  - Otherwise the output is `y[7:0]`.
  - The extra bit prevents overflow at `x` near +max.
- **Stage 1 (clamp register):** on the edge that samples `sys_valid=1`, stores the 24-bit pixel {R8,G8,B8} and sets `s1_valid`. Otherwise `s1_valid` is 0. This stage never stalls.
- **FIFO write:**
  - If `s1_valid` is 1 and the FIFO is not full, or it is full but a pop happens on the same edge, the pixel is pushed.
  - If the FIFO is full and there is no pop, the pixel is dropped and `overflow` is set to 1.
- **Overflow flag:** `clr_ovf` clears `overflow`. If a set and a clear happen on the same edge, the set wins.
- **FIFO read:** not first-word-fall-through. A pop happens when the FIFO is non-empty and the serializer is IDLE, or the serializer is accepting its B byte on that edge.
- **Serializer FSM:**
  - IDLE: `dout_valid=0`. On a pop, load the pixel and go to SEND_R.
  - SEND_R: `dout=R8`, `dout_first=1`. On accept, go to SEND_G.
  - SEND_G: `dout=G8`. On accept, go to SEND_B.
  - SEND_B: `dout=B8`. On accept, go to SEND_R if a pop happens on the same edge, otherwise to IDLE.
- **Output stability:** while `dout_valid=1` and `dout_ready=0`, `dout` and `dout_first` hold stable.
- **Capacity:** `FIFO_DEPTH` pixels in the FIFO plus 1 in the serializer.
- **Pointers:** read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Full and empty are derived from `fifo_level`.

## Timing
- **Reset values:**
  - `dout=0`, `dout_valid=0`, `dout_first=0`, `fifo_level=0`, `overflow=0`.
  - FSM in IDLE, `s1_valid=0`, pointers 0.
- **Latency:** `sys_valid` is sampled at edge k with the FIFO empty and the FSM in IDLE.
  - Edge k+1: FIFO write, `fifo_level=1`.
  - Edge k+2: pop; `dout_valid=1` with the R byte from edge k+2 onward.
- **Throughput:** one byte per cycle with `dout_ready` held high, and no gap between back-to-back pixels. This is 3 cycles per pixel against an input rate of at most 1 pixel per 4 cycles.
- **Simultaneous push and pop:** `fifo_level` is unchanged, including when the FIFO is full.
- **Reset mid-pixel:** asynchronous reset discards any partially sent pixel and all FIFO contents. Output resumes with a fresh pixel, and `dout_first` is asserted on its R byte.

## Structure
- **Shared package `cte_pkg`:**
  - `IN_FRAC=3`
  - `PIX_W=24`
  - typedef `rgb8_t` (struct of three 8-bit channels)
  - serializer state enum {IDLE, SEND_R, SEND_G, SEND_B}
  - function `clamp_round(x)`
- **Sub-module `pix_fifo`:** synchronous FIFO with width `PIX_W`, depth `FIFO_DEPTH`, ports push/pop/level/full/empty. It has no overflow logic; drop decisions stay in the top level.

## Test plan
- **Rounding and clamping:** inject pixels with R=800, G=20, B=19, then R=-40, G=2100, B=4095 (max +), with `dout_ready=1`.
  - Required: bytes 100, 3, 2, then 0, 255, 255.
  - `dout_first` high on the 100 and 0 bytes only.
- **Latency:** with the block idle, assert `sys_valid` at edge k.
  - Required: `dout_valid` rises after edge k+2 and `fifo_level` is 1 after edge k+1.
- **Back-to-back pixels:** strobe every 4 cycles for 16 pixels with `dout_ready=1`.
  - Required: 48 bytes in order, `fifo_level ≤ 1`, `overflow` stays 0.
- **Backpressure and overflow:** hold `dout_ready=0` and inject 10 pixels, 4 cycles apart (IN_W=13, FIFO_DEPTH=8).
  - Required: 9 pixels retained (`fifo_level=8` plus 1 in the serializer), the 10th dropped, `overflow=1`.
  - Then release `dout_ready`. Required: 27 bytes, matching pixels 1..9.
  - Pulse `clr_ovf`. Required: `overflow=0`.
- **Stall mid-pixel:** drop `dout_ready` while on the G byte for 5 cycles.
  - Required: `dout` holds the G value, then B follows, and no byte is lost or duplicated.
- **Asynchronous reset mid-stream:** assert `rstn=0` between clock edges while on the G byte with 3 pixels queued.
  - Required: all outputs go to reset values immediately.
  - After release, a new pixel appears with its R byte first.

Source files
------------

// File: rtl/rgb_clamp_pack_pkg.sv
// Shared types and helpers for the RGB clamp/pack stage.
package cte_pkg;

  localparam int unsigned IN_FRAC = 3;
  localparam int unsigned PIX_W   = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_R,
    SEND_G,
    SEND_B
  } ser_state_t;

  // Round half up and saturate a sign-extended fixed-point value to 8 bits.
  // The 32-bit working width covers IN_W+1 for any IN_W up to 31.
  function automatic logic [7:0] clamp_round(input logic signed [31:0] x);
    logic signed [31:0] y;
    y = (x + (32'sd1 <<< (IN_FRAC - 1))) >>> IN_FRAC;
    if (y < 32'sd0)
      clamp_round = 8'd0;
    else if (y > 32'sd255)
      clamp_round = 8'hFF;
    else
      clamp_round = y[7:0];
  endfunction

endpackage

// File: rtl/rgb_clamp_pack_if.sv
// Serial byte-stream handshake between the packer and its sink.
interface rgb_clamp_pack_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_first;

  modport master (output dout, output dout_valid, output dout_first, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_first, output dout_ready);
endinterface

// File: rtl/rgb_clamp_pack_fifo.sv
// Synchronous pixel FIFO; head word is read combinationally at mem[rptr].
module pix_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/rgb_clamp_pack.sv
// Clamp/round converter output to 8-bit RGB, buffer pixels, emit R,G,B bytes.
module rgb_clamp_pack
  import cte_pkg::*;
#(
  parameter int unsigned IN_W       = 13,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [IN_W-1:0]               R,
  input  logic [IN_W-1:0]               G,
  input  logic [IN_W-1:0]               B,
  input  logic                          sys_valid,
  input  logic                          clr_ovf,
  rgb_clamp_pack_if.master              stream,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  logic signed [IN_W-1:0] r_s, g_s, b_s;
  rgb8_t                  s1_pix;
  logic                   s1_valid;
  rgb8_t                  cur;
  ser_state_t             state;
  logic [PIX_W-1:0]       head;
  logic                   full, empty;
  logic                   accept, pop, push, drop;

  assign r_s = R;
  assign g_s = G;
  assign b_s = B;

  // Stage 1: clamp register, never stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
    end else begin
      s1_valid <= sys_valid;
      if (sys_valid)
        s1_pix <= {clamp_round(32'(r_s)), clamp_round(32'(g_s)), clamp_round(32'(b_s))};
    end
  end

  // Handshake decode: pop when idle or when the last byte of a pixel leaves.
  always_comb begin
    accept = (state != IDLE) && stream.dout_ready;
    pop    = !empty && ((state == IDLE) || ((state == SEND_B) && accept));
    push   = s1_valid && (!full || pop);
    drop   = s1_valid && full && !pop;
  end

  pix_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (s1_pix),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // Serializer: load a pixel on pop, step through R, G, B on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cur   <= '0;
    end else begin
      if (pop) cur <= rgb8_t'(head);
      case (state)
        IDLE:    if (pop)    state <= SEND_R;
        SEND_R:  if (accept) state <= SEND_G;
        SEND_G:  if (accept) state <= SEND_B;
        SEND_B:  if (accept) state <= pop ? SEND_R : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output byte is a pure decode of registered state, so it holds under stall.
  always_comb begin
    stream.dout_valid = (state != IDLE);
    stream.dout_first = (state == SEND_R);
    case (state)
      SEND_R:  stream.dout = cur.r;
      SEND_G:  stream.dout = cur.g;
      SEND_B:  stream.dout = cur.b;
      default: stream.dout = '0;
    endcase
  end

  // Sticky overflow; a drop on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule
